// File: rtl/sleep_cycle_controller.sv
// Sleep/wake sequencer: AWAKE -> DROWSY -> SLEEP_LIGHT -> SLEEP_DEEP -> WAKING, driving energy recovery requests.
// Optional build macro SLEEP_DISTURB_FILTER_EN adds a consecutive-tick disturbance filter.
module sleep_cycle_controller #(
    parameter int DROWSY_TICKS   = 4,
    parameter int LIGHT_TICKS    = 8,
    parameter int DEEP_MIN_TICKS = 16,
    parameter int WAKE_TICKS     = 2,
    parameter int DISTURB_TICKS  = 3,
    parameter int CNT_W          = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] vital_energy_level,
    input  logic       vital_energy_zero,
    input  logic       disturb,
    output logic       drowsy,
    output logic       sleeping,
    output logic       deep_sleep,
    output logic       energy_recover,
    output logic       energy_recover_fast,
    output logic       wake_event,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        AWAKE       = 3'd0,
        DROWSY      = 3'd1,
        SLEEP_LIGHT = 3'd2,
        SLEEP_DEEP  = 3'd3,
        WAKING      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DROWSY_LAST = CNT_W'(DROWSY_TICKS - 1);
    localparam logic [CNT_W-1:0] LIGHT_LAST  = CNT_W'(LIGHT_TICKS - 1);
    localparam logic [CNT_W-1:0] DEEP_LAST   = CNT_W'(DEEP_MIN_TICKS - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST   = CNT_W'(WAKE_TICKS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_hold;
    logic             wake_d;
    logic             dist_q;
    logic             state_change;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign state_change = (state_d != state_q);

`ifdef SLEEP_DISTURB_FILTER_EN
    localparam int                FILT_W   = $clog2(DISTURB_TICKS + 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(DISTURB_TICKS);

    logic [FILT_W-1:0] filt_q;
    logic [FILT_W-1:0] filt_d;
    logic [FILT_W-1:0] filt_next;

    function automatic logic [FILT_W-1:0] sat_inc_filt(input logic [FILT_W-1:0] v);
        return (v >= FILT_MAX) ? FILT_MAX : v + 1'b1;
    endfunction

    // Count of consecutive disturbed ticks; a single quiet tick resets it.
    assign filt_next = disturb ? sat_inc_filt(filt_q) : '0;
    assign dist_q    = disturb && (filt_next == FILT_MAX);

    always_comb begin
        filt_d = filt_q;
        if (state_change) begin
            filt_d = '0;
        end else if (tick) begin
            filt_d = filt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_d;
        end
    end
`else
    logic unused_filter_cfg;

    // Without the filter a single disturbed tick counts.
    assign dist_q            = disturb;
    assign unused_filter_cfg = (DISTURB_TICKS > 0);
`endif

    // Next-state selection; only evaluated on tick except for illegal codes.
    always_comb begin
        state_d  = state_q;
        cnt_hold = 1'b0;
        wake_d   = 1'b0;
        case (state_q)
            AWAKE: begin
                if (tick) begin
                    if (vital_energy_zero) begin
                        state_d = SLEEP_LIGHT;
                    end else if (vital_energy_level == 2'd0) begin
                        state_d = DROWSY;
                    end
                end
            end
            DROWSY: begin
                if (tick) begin
                    if (vital_energy_level >= 2'd2) begin
                        state_d = AWAKE;
                    end else if (disturb) begin
                        cnt_hold = 1'b1;
                    end else if (cnt_q == DROWSY_LAST) begin
                        state_d = SLEEP_LIGHT;
                    end
                end
            end
            SLEEP_LIGHT: begin
                if (tick) begin
                    if (dist_q) begin
                        state_d = WAKING;
                    end else if (cnt_q == LIGHT_LAST) begin
                        state_d = SLEEP_DEEP;
                    end
                end
            end
            SLEEP_DEEP: begin
                if (tick) begin
                    if (dist_q) begin
                        state_d = SLEEP_LIGHT;
                    end else if ((vital_energy_level == 2'd3) && (cnt_q >= DEEP_LAST)) begin
                        state_d = WAKING;
                    end
                end
            end
            WAKING: begin
                if (tick && (cnt_q == WAKE_LAST)) begin
                    state_d = AWAKE;
                    wake_d  = 1'b1;
                end
            end
            default: begin
                state_d = AWAKE;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_change) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_hold ? '0 : sat_inc_cnt(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= AWAKE;
            cnt_q      <= '0;
            wake_event <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wake_event <= wake_d;
        end
    end

    assign state               = state_q;
    assign drowsy              = (state_q == DROWSY);
    assign sleeping            = (state_q == SLEEP_LIGHT) || (state_q == SLEEP_DEEP);
    assign deep_sleep          = (state_q == SLEEP_DEEP);
    assign energy_recover      = sleeping;
    assign energy_recover_fast = deep_sleep;

endmodule

// File: tb/tb_sleep_cycle_controller.sv
// Bench for sleep_cycle_controller: directed scenarios plus randomized traffic against a behavioural model.
// Honours SLEEP_DISTURB_FILTER_EN the same way the design does.
module tb_sleep_cycle_controller;

    localparam int DROWSY_TICKS   = 4;
    localparam int LIGHT_TICKS    = 8;
    localparam int DEEP_MIN_TICKS = 16;
    localparam int WAKE_TICKS     = 2;
    localparam int DISTURB_TICKS  = 3;
    localparam int CNT_W          = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] level = 2'd3;
    logic       zero = 1'b0;
    logic       disturb = 1'b0;
    logic       drowsy;
    logic       sleeping;
    logic       deep_sleep;
    logic       energy_recover;
    logic       energy_recover_fast;
    logic       wake_event;
    logic [2:0] state;

    sleep_cycle_controller #(
        .DROWSY_TICKS  (DROWSY_TICKS),
        .LIGHT_TICKS   (LIGHT_TICKS),
        .DEEP_MIN_TICKS(DEEP_MIN_TICKS),
        .WAKE_TICKS    (WAKE_TICKS),
        .DISTURB_TICKS (DISTURB_TICKS),
        .CNT_W         (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tick               (tick),
        .vital_energy_level (level),
        .vital_energy_zero  (zero),
        .disturb            (disturb),
        .drowsy             (drowsy),
        .sleeping           (sleeping),
        .deep_sleep         (deep_sleep),
        .energy_recover     (energy_recover),
        .energy_recover_fast(energy_recover_fast),
        .wake_event         (wake_event),
        .state              (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase number, ticks spent in phase, consecutive disturbed ticks.
    int m_phase = 0;
    int m_dwell = 0;
    int m_run   = 0;
    bit m_wake  = 1'b0;

    logic [8:0] obs;
    assign obs = {state, drowsy, sleeping, deep_sleep, energy_recover, energy_recover_fast, wake_event};

    function automatic logic [8:0] expv();
        bit asleep;
        asleep = (m_phase == 2) || (m_phase == 3);
        return {3'(m_phase), (m_phase == 1), asleep, (m_phase == 3), asleep, (m_phase == 3), m_wake};
    endfunction

    function automatic void model_step(input bit r, input bit t, input int l, input bit z, input bit d);
        int  nxt;
        int  run;
        bit  eff;
        bit  restart;
        m_wake = 1'b0;
        if (r) begin
            m_phase = 0;
            m_dwell = 0;
            m_run   = 0;
            return;
        end
        if (!t) return;
        run = d ? ((m_run + 1 > DISTURB_TICKS) ? DISTURB_TICKS : m_run + 1) : 0;
`ifdef SLEEP_DISTURB_FILTER_EN
        eff = d && (run == DISTURB_TICKS);
`else
        eff = d;
`endif
        nxt     = m_phase;
        restart = 1'b0;
        if (m_phase == 0) begin
            if (z) nxt = 2;
            else if (l == 0) nxt = 1;
        end else if (m_phase == 1) begin
            if (l >= 2) nxt = 0;
            else if (d) restart = 1'b1;
            else if (m_dwell + 1 >= DROWSY_TICKS) nxt = 2;
        end else if (m_phase == 2) begin
            if (eff) nxt = 4;
            else if (m_dwell + 1 >= LIGHT_TICKS) nxt = 3;
        end else if (m_phase == 3) begin
            if (eff) nxt = 2;
            else if (l == 3 && m_dwell + 1 >= DEEP_MIN_TICKS) nxt = 4;
        end else if (m_phase == 4) begin
            if (m_dwell + 1 >= WAKE_TICKS) begin
                nxt    = 0;
                m_wake = 1'b1;
            end
        end else begin
            nxt = 0;
        end
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_dwell = 0;
            m_run   = 0;
        end else begin
            m_dwell = restart ? 0 : ((m_dwell >= (1 << CNT_W) - 1) ? m_dwell : m_dwell + 1);
            m_run   = run;
        end
    endfunction

    task automatic cycle(input bit r, input bit t, input logic [1:0] l, input bit z, input bit d);
        rst     = r;
        tick    = t;
        level   = l;
        zero    = z;
        disturb = d;
        @(posedge clk);
        model_step(r, t, int'(l), z, d);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
        total++;
        if (obs !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %09b want %09b", obs, 9'd0);
        end
        cycle(1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        total++;
        if (obs !== 9'd0) begin
            bad++;
            $display("FAIL reset_release_idle: got %09b want %09b", obs, 9'd0);
        end
    endtask

    task automatic test_sleep_entry();
        for (int i = 1; i <= 13; i++) begin
            cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++;
                $display("FAIL entry_model tick%0d: got %09b want %09b", i, obs, expv());
            end
            if (i == 1 || i == 5 || i == 13) begin
                total++;
                if (state !== ((i == 1) ? 3'd1 : (i == 5) ? 3'd2 : 3'd3)) begin
                    bad++;
                    $display("FAIL entry_state tick%0d: got %0d want %0d", i, state,
                             (i == 1) ? 1 : (i == 5) ? 2 : 3);
                end
            end
        end
        total++;
        if ({energy_recover, energy_recover_fast} !== 2'b11) begin
            bad++;
            $display("FAIL entry_recover_deep: got %02b want 11", {energy_recover, energy_recover_fast});
        end
    endtask

    task automatic test_deep_wake();
        int pulses;
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
            total++;
            if (state !== ((i < 16) ? 3'd3 : 3'd4)) begin
                bad++;
                $display("FAIL deep_dwell tick%0d: got %0d want %0d", i, state, (i < 16) ? 3 : 4);
            end
        end
        cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        pulses += int'(wake_event);
        total++;
        if (obs !== expv() || state !== 3'd4) begin
            bad++;
            $display("FAIL waking_first: got %09b want %09b", obs, expv());
        end
        cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        pulses += int'(wake_event);
        total++;
        if (state !== 3'd0 || wake_event !== 1'b1) begin
            bad++;
            $display("FAIL wake_arrive: got state=%0d wake=%0b want state=0 wake=1", state, wake_event);
        end
        cycle(1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        pulses += int'(wake_event);
        cycle(1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        pulses += int'(wake_event);
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL wake_pulse_width: got %0d want 1", pulses);
        end
    endtask

    task automatic test_collapse();
        cycle(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
        total++;
        if (state !== 3'd2 || drowsy !== 1'b0 || energy_recover !== 1'b1) begin
            bad++;
            $display("FAIL collapse: got state=%0d drowsy=%0b rec=%0b want state=2 drowsy=0 rec=1",
                     state, drowsy, energy_recover);
        end
    endtask

    task automatic test_disturb();
        cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
`ifdef SLEEP_DISTURB_FILTER_EN
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL disturb_single: got %0d want 2", state);
        end
        cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL disturb_second: got %0d want 2", state);
        end
        cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
`endif
        total++;
        if (state !== 3'd4) begin
            bad++;
            $display("FAIL disturb_wake: got %0d want 4", state);
        end
        cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        total++;
        if (obs !== expv() || state !== 3'd0) begin
            bad++;
            $display("FAIL disturb_ignored_waking: got %09b want %09b", obs, expv());
        end
    endtask

    task automatic test_reset_mid_sleep();
        cycle(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < LIGHT_TICKS + 10; i++) cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        total++;
        if (state !== 3'd3) begin
            bad++;
            $display("FAIL midsleep_setup: got %0d want 3", state);
        end
        cycle(1'b1, 1'b1, 2'd3, 1'b1, 1'b1);
        total++;
        if (obs !== 9'd0) begin
            bad++;
            $display("FAIL midsleep_reset: got %09b want %09b", obs, 9'd0);
        end
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
            total++;
            if (obs !== expv() || (i == 1 && state !== 3'd1) || (i == 5 && state !== 3'd2)) begin
                bad++;
                $display("FAIL midsleep_restart tick%0d: got %09b want %09b", i, obs, expv());
            end
        end
    endtask

    task automatic test_random();
        int dprob;
        int lmode;
        bit r;
        bit t;
        bit z;
        bit d;
        logic [1:0] l;
        cycle(1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
        for (int seg = 0; seg < 24; seg++) begin
            dprob = (seg % 3 == 0) ? 0 : (seg % 3 == 1) ? 8 : 45;
            lmode = $urandom_range(0, 2);
            for (int i = 0; i < 160; i++) begin
                r = ($urandom_range(0, 299) == 0);
                t = ($urandom_range(0, 3) != 0);
                z = ($urandom_range(0, 24) == 0);
                d = ($urandom_range(0, 99) < dprob);
                if (lmode == 0) l = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
                else if (lmode == 1) l = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd3;
                else l = 2'($urandom_range(0, 3));
                cycle(r, t, l, z, d);
                total++;
                if (obs !== expv()) begin
                    bad++;
                    $display("FAIL random seg%0d cyc%0d: got %09b want %09b", seg, i, obs, expv());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sleep_entry();
        test_deep_wake();
        test_collapse();
        test_disturb();
        test_reset_mid_sleep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
